truth_table_sequencer: RTL and testbench



---
 rtl/truth_table_sequencer_pkg.sv | 23 ++
 rtl/truth_table_sequencer_if.sv | 29 ++
 rtl/truth_table_sequencer_hold_timer.sv | 40 ++++
 rtl/truth_table_sequencer.sv | 122 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Purpose : shared types and width helpers for the truth-table sequencer.
// Contents: FSM state encoding, table width and hold-counter width helpers.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Table width T = 2**N_IN.
  function automatic int table_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Hold counter width = max(1, clog2(HOLD)).
  function automatic int hold_width(input int hold);
    int w;
    w = $clog2(hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Purpose : bundles the request side and network side of the sequencer.
// Ports   : start_i/expected_i (request), net_in_o/net_out_i (network),
//           busy_o/done_o/table_o/mismatch_o/first_bad_o (result).
//           slave = sequencer, master = requester plus network under test.
interface truth_table_sequencer_if #(
  parameter int N_IN = 2
) ();
  localparam int T = 1 << N_IN;

  logic            start_i;
  logic [T-1:0]    expected_i;
  logic [N_IN-1:0] net_in_o;
  logic            net_out_i;
  logic            busy_o;
  logic            done_o;
  logic [T-1:0]    table_o;
  logic            mismatch_o;
  logic [N_IN-1:0] first_bad_o;

  modport slave (
    input  start_i, expected_i, net_out_i,
    output net_in_o, busy_o, done_o, table_o, mismatch_o, first_bad_o
  );

  modport master (
    output start_i, expected_i, net_out_i,
    input  net_in_o, busy_o, done_o, table_o, mismatch_o, first_bad_o
  );
endinterface

// File: rtl/truth_table_sequencer_hold_timer.sv
// Purpose : clearable hold counter; last_o is high while count == HOLD-1.
// Ports   : clock, reset_n (async active-low), clr_i (synchronous clear),
//           en_i (count enable), last_o (terminal-count strobe).
module truth_table_sequencer_hold_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int HOLD = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  localparam int HW = hold_width(HOLD);
  localparam logic [HW-1:0] LAST_CNT = HW'(HOLD - 1);

  logic [HW-1:0] count_q;
  logic [HW-1:0] count_d;

  assign last_o = (count_q == LAST_CNT);

  // Wraps to zero on the terminal count so each combination gets HOLD cycles.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/truth_table_sequencer.sv
// Purpose : sweeps every input combination of a small combinational network,
//           holds each for HOLD cycles, samples the output on the last hold
//           cycle, and compares the captured table against a latched one.
// Ports   : clock, reset_n (async active-low), bus (slave modport):
//           start_i, expected_i, net_out_i in; net_in_o, busy_o, done_o,
//           table_o, mismatch_o, first_bad_o out.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | net_in=0, waiting for start; start latches expected
// ST_APPLY | busy, net_in=index, sample net_out on last hold cycle
// ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int HOLD = 3
) (
  input logic                     clock,
  input logic                     reset_n,
  truth_table_sequencer_if.slave  bus
);
  localparam int T = table_width(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(T - 1);

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] net_in_q;
  logic            busy_q;
  logic            done_q;
  logic [T-1:0]    tbl_q;
  logic [T-1:0]    exp_q;

  logic            start_ok;
  logic            apply_en;
  logic            hold_last;
  logic [T-1:0]    diff;
  logic [N_IN-1:0] first_bad;

  assign start_ok = (state_q == ST_IDLE) && bus.start_i;
  assign apply_en = (state_q == ST_APPLY);

  truth_table_sequencer_hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (start_ok),
    .en_i    (apply_en),
    .last_o  (hold_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      net_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tbl_q    <= '0;
      exp_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          net_in_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          if (bus.start_i) begin
            exp_q   <= bus.expected_i;
            tbl_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (hold_last) begin
            tbl_q[idx_q] <= bus.net_out_i;
            if (idx_q == LAST_IDX) begin
              // Finish instead of wrapping the index.
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              net_in_q <= '0;
            end else begin
              idx_q    <= idx_q + 1'b1;
              net_in_q <= idx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          net_in_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // Descending scan so the lowest differing index is the one that sticks.
  always_comb begin
    diff      = tbl_q ^ exp_q;
    first_bad = '0;
    for (int i = T - 1; i >= 0; i--) begin
      if (diff[i]) begin
        first_bad = N_IN'(i);
      end
    end
  end

  assign bus.net_in_o    = net_in_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.table_o     = tbl_q;
  assign bus.mismatch_o  = |diff;
  assign bus.first_bad_o = first_bad;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Purpose : self-checking bench for truth_table_sequencer with four
//           instances: default AND/XOR network, N_IN=3/HOLD=1 OR network,
//           and a slow-settling network at HOLD=3 and HOLD=2.
module tb_truth_table_sequencer;

  typedef struct {
    logic [7:0] tbl;
    logic       mm;
    logic [2:0] fb;
  } exp_t;

  logic clock;
  logic reset_n;
  logic start_r;
  logic [7:0] exp_r;
  int   sel;
  bit   mode;
  int   n_run;
  int   n_fail;
  exp_t sb[$];

  logic [1:0] p2_d1 = '0, p2_d2 = '0;
  logic [1:0] p3_d1 = '0, p3_d2 = '0;

  logic [2:0] g_net_in;
  logic [7:0] g_table;
  logic [2:0] g_fb;
  logic       g_busy, g_done, g_mm;

  truth_table_sequencer_if #(.N_IN(2)) if0 ();
  truth_table_sequencer_if #(.N_IN(3)) if1 ();
  truth_table_sequencer_if #(.N_IN(2)) if2 ();
  truth_table_sequencer_if #(.N_IN(2)) if3 ();

  truth_table_sequencer #(.N_IN(2), .HOLD(3)) u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
  truth_table_sequencer #(.N_IN(3), .HOLD(1)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));
  truth_table_sequencer #(.N_IN(2), .HOLD(3)) u2 (.clock(clock), .reset_n(reset_n), .bus(if2));
  truth_table_sequencer #(.N_IN(2), .HOLD(2)) u3 (.clock(clock), .reset_n(reset_n), .bus(if3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign if0.start_i    = start_r && (sel == 0);
  assign if1.start_i    = start_r && (sel == 1);
  assign if2.start_i    = start_r && (sel == 2);
  assign if3.start_i    = start_r && (sel == 3);
  assign if0.expected_i = exp_r[3:0];
  assign if1.expected_i = exp_r;
  assign if2.expected_i = exp_r[3:0];
  assign if3.expected_i = exp_r[3:0];

  // Networks under test.
  assign if0.net_out_i = mode ? (^if0.net_in_o) : (&if0.net_in_o);
  assign if1.net_out_i = |if1.net_in_o;
  always @(posedge clock) begin
    p2_d1 <= if2.net_in_o;
    p2_d2 <= p2_d1;
    p3_d1 <= if3.net_in_o;
    p3_d2 <= p3_d1;
  end
  assign if2.net_out_i = ^p2_d2;
  assign if3.net_out_i = ^p3_d2;

  always_comb begin
    g_net_in = '0; g_table = '0; g_fb = '0;
    g_busy = 1'b0; g_done = 1'b0; g_mm = 1'b0;
    case (sel)
      0: begin
        g_net_in = {1'b0, if0.net_in_o}; g_table = {4'b0, if0.table_o};
        g_fb = {1'b0, if0.first_bad_o}; g_busy = if0.busy_o;
        g_done = if0.done_o; g_mm = if0.mismatch_o;
      end
      1: begin
        g_net_in = if1.net_in_o; g_table = if1.table_o;
        g_fb = if1.first_bad_o; g_busy = if1.busy_o;
        g_done = if1.done_o; g_mm = if1.mismatch_o;
      end
      2: begin
        g_net_in = {1'b0, if2.net_in_o}; g_table = {4'b0, if2.table_o};
        g_fb = {1'b0, if2.first_bad_o}; g_busy = if2.busy_o;
        g_done = if2.done_o; g_mm = if2.mismatch_o;
      end
      default: begin
        g_net_in = {1'b0, if3.net_in_o}; g_table = {4'b0, if3.table_o};
        g_fb = {1'b0, if3.first_bad_o}; g_busy = if3.busy_o;
        g_done = if3.done_o; g_mm = if3.mismatch_o;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected sample for index i. The slow networks output f(net_in) from two
  // cycles earlier, so with a short hold they report the previous combination.
  function automatic logic cap_bit(input int s, input bit m, input int i, input int h);
    int j;
    case (s)
      0: return m ? (i == 1 || i == 2) : (i == 3);
      1: return (i != 0);
      default: begin
        if ((i + 1) * h - 2 >= 1) j = ((i + 1) * h - 3) / h;
        else j = 0;
        return (j == 1 || j == 2);
      end
    endcase
  endfunction

  task automatic run_sweep(input int s, input int nin, input int h, input logic [7:0] expv,
                           input int extra_c, input bit start_at_done);
    int   n_t;
    int   n;
    bit   found;
    exp_t e;
    exp_t got;
    n_t = 1 << nin;
    n   = n_t * h;
    e.tbl = '0;
    for (int i = 0; i < n_t; i++) e.tbl[i] = cap_bit(s, mode, i, h);
    e.mm  = (e.tbl != expv);
    e.fb  = '0;
    found = 1'b0;
    for (int i = 0; i < n_t; i++) begin
      if (!found && (e.tbl[i] != expv[i])) begin
        e.fb  = 3'(i);
        found = 1'b1;
      end
    end
    sel     = s;
    exp_r   = expv;
    start_r = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    for (int c = 1; c <= n; c++) begin
      start_r = (c == extra_c);
      if (c == 1) begin
        exp_r = ~expv;  // latched copy must be used, not the live input
        chk("table_cleared", 32'(g_table), 32'd0);
      end
      chk("busy_sweep", 32'(g_busy), 32'd1);
      chk("done_early", 32'(g_done), 32'd0);
      chk("net_in_step", 32'(g_net_in), 32'((c - 1) / h));
      @(negedge clock);
    end
    start_r = start_at_done;
    chk("done_pulse", 32'(g_done), 32'd1);
    chk("busy_at_done", 32'(g_busy), 32'd0);
    chk("net_in_at_done", 32'(g_net_in), 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("table", 32'(g_table), 32'(got.tbl));
      chk("mismatch", 32'(g_mm), 32'(got.mm));
      chk("first_bad", 32'(g_fb), 32'(got.fb));
    end
    @(negedge clock);
    start_r = 1'b0;
    chk("done_single", 32'(g_done), 32'd0);
    chk("idle_after_done", 32'(g_busy), 32'd0);
    chk("table_hold", 32'(g_table), 32'(e.tbl));
  endtask

  initial begin
    n_run   = 0;
    n_fail  = 0;
    sel     = 0;
    mode    = 1'b0;
    start_r = 1'b0;
    exp_r   = '0;
    reset_n = 1'b0;
    #2;
    chk("rst_net_in", 32'(g_net_in), 32'd0);
    chk("rst_busy", 32'(g_busy), 32'd0);
    chk("rst_done", 32'(g_done), 32'd0);
    chk("rst_table", 32'(g_table), 32'd0);
    chk("rst_mismatch", 32'(g_mm), 32'd0);
    chk("rst_first_bad", 32'(g_fb), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // AND network, matching expectation.
    mode = 1'b0;
    run_sweep(0, 2, 3, 8'h08, -1, 1'b0);

    // XOR network with re-pulsed start at t+5 and at done, then a new sweep at t+14.
    mode = 1'b1;
    run_sweep(0, 2, 3, 8'h08, 5, 1'b1);
    mode = 1'b0;
    run_sweep(0, 2, 3, 8'h08, -1, 1'b0);

    // Reset mid-sweep at t+7.
    mode    = 1'b1;
    sel     = 0;
    exp_r   = 8'h08;
    start_r = 1'b1;
    @(negedge clock);
    start_r = 1'b0;
    repeat (6) @(negedge clock);
    chk("mid_net_in", 32'(g_net_in), 32'd2);
    chk("mid_table", 32'(g_table), 32'h2);
    reset_n = 1'b0;
    #1;
    chk("abort_net_in", 32'(g_net_in), 32'd0);
    chk("abort_busy", 32'(g_busy), 32'd0);
    chk("abort_table", 32'(g_table), 32'd0);
    chk("abort_done", 32'(g_done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("post_rst_busy", 32'(g_busy), 32'd0);
      chk("post_rst_net_in", 32'(g_net_in), 32'd0);
    end

    // N_IN=3, HOLD=1, OR network.
    run_sweep(1, 3, 1, 8'hFE, -1, 1'b0);

    // Slow-settling network: enough hold, then too little.
    run_sweep(2, 2, 3, 8'h06, -1, 1'b0);
    run_sweep(3, 2, 2, 8'h06, -1, 1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
